// File: rtl/baud_cfg_ctrl_pkg.sv
// Shared UART configuration definitions: controller state encoding, power-up
// defaults and the baud rates the clock generator is able to produce.
package baud_cfg_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        APPLY,
        CHECK,
        LOCK,
        DONE,
        FAIL
    } cfg_state_t;

    localparam logic [31:0] DEFAULT_BAUD = 32'd9600;
    localparam logic [31:0] DEFAULT_CLK  = 32'd50000000;

    localparam logic [31:0] BAUD_9600   = 32'd9600;
    localparam logic [31:0] BAUD_19200  = 32'd19200;
    localparam logic [31:0] BAUD_38400  = 32'd38400;
    localparam logic [31:0] BAUD_57600  = 32'd57600;
    localparam logic [31:0] BAUD_115200 = 32'd115200;

endpackage

// File: rtl/baud_cfg_ctrl_timer.sv
// Reloadable down-counter shared by the CHECK and LOCK phases; it holds at
// zero once it runs out.
module cfg_timer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 32'd1;
        end
    end

endmodule

// File: rtl/baud_cfg_ctrl.sv
// Baud-rate reconfiguration controller: drains the UART, reprograms the baud
// generator, verifies lock and falls back to the last good setting on failure.
module baud_cfg_ctrl #(
    parameter logic [31:0] DEFAULT_BAUD = baud_cfg_ctrl_pkg::DEFAULT_BAUD,
    parameter logic [31:0] DEFAULT_CLK  = baud_cfg_ctrl_pkg::DEFAULT_CLK,
    parameter int unsigned CHECK_CYCLES = 4,
    parameter int unsigned LOCK_TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cfg_req,
    input  logic [31:0] cfg_baud,
    input  logic [31:0] cfg_clk,
    input  logic        tx_busy,
    input  logic        rx_busy,
    input  logic        BR_config_error,
    input  logic        bclk,
    output logic [31:0] BAUD_RATE,
    output logic [31:0] CLK_FREQ,
    output logic        bclk_en,
    output logic        uart_hold,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_rej,
    output logic        cfg_err
);

    import baud_cfg_ctrl_pkg::*;

    cfg_state_t  state;
    cfg_state_t  state_nxt;
    logic [31:0] pend_baud;
    logic [31:0] pend_clk;
    logic [31:0] good_baud;
    logic [31:0] good_clk;
    logic        revert;
    logic        bclk_q;
    logic        bclk_toggle;
    logic        bclk_en_nxt;
    logic        tmr_load;
    logic [31:0] tmr_val;
    logic [31:0] tmr_count;
    logic        tmr_last;

    cfg_timer u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count)
    );

    assign bclk_toggle = (bclk != bclk_q);
    // A count of one means the current cycle is the last of the window.
    assign tmr_last    = (tmr_count <= 32'd1);
    assign uart_hold   = (state != IDLE);
    assign cfg_busy    = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        bclk_en_nxt = bclk_en;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        case (state)
            IDLE: begin
                if (cfg_req) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!tx_busy && !rx_busy) begin
                    state_nxt   = APPLY;
                    bclk_en_nxt = 1'b0;
                end
            end
            APPLY: begin
                state_nxt   = CHECK;
                bclk_en_nxt = 1'b1;
                tmr_load    = 1'b1;
                tmr_val     = 32'(CHECK_CYCLES);
            end
            CHECK: begin
                if (BR_config_error) begin
                    state_nxt = FAIL;
                end else if (tmr_last) begin
                    state_nxt = LOCK;
                    tmr_load  = 1'b1;
                    tmr_val   = 32'(LOCK_TIMEOUT);
                end
            end
            LOCK: begin
                // An error wins over a toggle seen in the same cycle.
                if (BR_config_error || (!bclk_toggle && tmr_last)) begin
                    state_nxt = FAIL;
                end else if (bclk_toggle) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            FAIL: begin
                bclk_en_nxt = 1'b0;
                state_nxt   = revert ? IDLE : APPLY;
            end
            default: begin
                state_nxt   = APPLY;
                bclk_en_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= APPLY;
            BAUD_RATE <= DEFAULT_BAUD;
            CLK_FREQ  <= DEFAULT_CLK;
            pend_baud <= DEFAULT_BAUD;
            pend_clk  <= DEFAULT_CLK;
            good_baud <= DEFAULT_BAUD;
            good_clk  <= DEFAULT_CLK;
            revert    <= 1'b0;
            bclk_en   <= 1'b0;
            bclk_q    <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_rej   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            bclk_en  <= bclk_en_nxt;
            bclk_q   <= bclk;
            cfg_done <= (state == DONE) || (state == FAIL && revert);
            cfg_rej  <= cfg_req && (state != IDLE);
            case (state)
                IDLE: begin
                    if (cfg_req) begin
                        pend_baud <= cfg_baud;
                        pend_clk  <= cfg_clk;
                        cfg_err   <= 1'b0;
                        revert    <= 1'b0;
                    end
                end
                APPLY: begin
                    BAUD_RATE <= pend_baud;
                    CLK_FREQ  <= pend_clk;
                end
                DONE: begin
                    good_baud <= pend_baud;
                    good_clk  <= pend_clk;
                    revert    <= 1'b0;
                end
                FAIL: begin
                    cfg_err <= 1'b1;
                    if (!revert) begin
                        pend_baud <= good_baud;
                        pend_clk  <= good_clk;
                        revert    <= 1'b1;
                    end else begin
                        revert <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Self-checking bench for baud_cfg_ctrl with a behavioural baud generator and
// an outcome model derived from the configuration rules.
module tb_baud_cfg_ctrl;

    import baud_cfg_ctrl_pkg::*;

    localparam int CHECK_N   = 4;
    localparam int TIMEOUT_B = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, cfg_req, tx_busy, rx_busy, br_err, bclk;
    logic [31:0] cfg_baud, cfg_clk, baud_rate, clk_freq;
    logic        bclk_en, uart_hold, cfg_busy, cfg_done, cfg_rej, cfg_err;

    logic        rstn_b, cfg_req_b;
    logic [31:0] cfg_baud_b, baud_rate_b, clk_freq_b;
    logic        bclk_en_b, uart_hold_b, cfg_busy_b, cfg_done_b, cfg_rej_b, cfg_err_b;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [31:0] good_baud = DEFAULT_BAUD;
    logic [31:0] good_clk  = DEFAULT_CLK;

    baud_cfg_ctrl #(
        .CHECK_CYCLES (CHECK_N),
        .LOCK_TIMEOUT (65536)
    ) dut (
        .clk (clk), .rstn (rstn), .cfg_req (cfg_req), .cfg_baud (cfg_baud),
        .cfg_clk (cfg_clk), .tx_busy (tx_busy), .rx_busy (rx_busy),
        .BR_config_error (br_err), .bclk (bclk), .BAUD_RATE (baud_rate),
        .CLK_FREQ (clk_freq), .bclk_en (bclk_en), .uart_hold (uart_hold),
        .cfg_busy (cfg_busy), .cfg_done (cfg_done), .cfg_rej (cfg_rej),
        .cfg_err (cfg_err)
    );

    baud_cfg_ctrl #(
        .CHECK_CYCLES (CHECK_N),
        .LOCK_TIMEOUT (TIMEOUT_B)
    ) dut_b (
        .clk (clk), .rstn (rstn_b), .cfg_req (cfg_req_b), .cfg_baud (cfg_baud_b),
        .cfg_clk (DEFAULT_CLK), .tx_busy (1'b0), .rx_busy (1'b0),
        .BR_config_error (1'b0), .bclk (1'b0), .BAUD_RATE (baud_rate_b),
        .CLK_FREQ (clk_freq_b), .bclk_en (bclk_en_b), .uart_hold (uart_hold_b),
        .cfg_busy (cfg_busy_b), .cfg_done (cfg_done_b), .cfg_rej (cfg_rej_b),
        .cfg_err (cfg_err_b)
    );

    function automatic bit supported(input logic [31:0] b);
        return (b == BAUD_9600) || (b == BAUD_19200) || (b == BAUD_38400) ||
               (b == BAUD_57600) || (b == BAUD_115200);
    endfunction

    // Generator model: toggles bclk every clk/(16*baud) enabled cycles and
    // flags any baud rate it cannot produce while enabled.
    longint gen_cnt;
    longint gen_div;
    always_comb begin
        gen_div = (baud_rate == 0) ? 64'd1 : longint'(clk_freq) / (longint'(baud_rate) * 16);
        if (gen_div < 1) gen_div = 1;
    end
    assign br_err = bclk_en && !supported(baud_rate);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gen_cnt <= 0;
            bclk    <= 1'b0;
        end else if (!bclk_en) begin
            gen_cnt <= 0;
        end else if (gen_cnt + 1 >= gen_div) begin
            gen_cnt <= 0;
            bclk    <= ~bclk;
        end else begin
            gen_cnt <= gen_cnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] b, input logic [31:0] f);
        cfg_baud = b;
        cfg_clk  = f;
        cfg_req  = 1'b1;
        step();
        cfg_req  = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            step();
            cycles++;
            if (cfg_done) seen = 1'b1;
        end
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    // One full request on the main DUT; the expected outcome comes from the
    // rules: supported rates stick, anything else reverts to the last good one.
    task automatic runConfig(input string tag, input logic [31:0] b, input logic [31:0] f,
                             input int busy, input bit use_tx, input bit inject_rej);
        logic [31:0] exp_b, exp_f, exp_e;
        int          cyc;
        bit          reached;
        if (supported(b)) begin
            exp_b = b; exp_f = f; exp_e = 0;
        end else begin
            exp_b = good_baud; exp_f = good_clk; exp_e = 1;
        end
        tx_busy = use_tx && (busy > 0);
        rx_busy = !use_tx && (busy > 0);
        applyStimulus(b, f);
        for (int i = 0; i < busy; i++) begin
            checkOutput({tag, "_drain_hold"}, 32'(uart_hold), 32'd1);
            checkOutput({tag, "_drain_baud"}, baud_rate, good_baud);
            step();
        end
        tx_busy = 1'b0;
        rx_busy = 1'b0;
        if (inject_rej) begin
            reached = 1'b0;
            for (int i = 0; i < 50 && !reached; i++) begin
                if (baud_rate == b) reached = 1'b1;
                else step();
            end
            checkOutput({tag, "_reach_check"}, 32'(reached), 32'd1);
            cfg_baud = BAUD_57600;
            cfg_req  = 1'b1;
            step();
            cfg_req  = 1'b0;
            checkOutput({tag, "_rej_pulse"}, 32'(cfg_rej), 32'd1);
        end
        waitDone(tag, 3000, cyc);
        checkOutput({tag, "_baud"}, baud_rate, exp_b);
        checkOutput({tag, "_clk"}, clk_freq, exp_f);
        checkOutput({tag, "_err"}, 32'(cfg_err), exp_e);
        checkOutput({tag, "_bclk_en"}, 32'(bclk_en), 32'd1);
        checkOutput({tag, "_hold_released"}, 32'(uart_hold), 32'd0);
        step();
        checkOutput({tag, "_done_pulse"}, 32'(cfg_done), 32'd0);
        checkOutput({tag, "_rej_idle"}, 32'(cfg_rej), 32'd0);
        if (supported(b)) begin
            good_baud = b;
            good_clk  = f;
        end
    endtask

    task automatic checkResetB(input string tag);
        checkOutput({tag, "_baud"}, baud_rate_b, DEFAULT_BAUD);
        checkOutput({tag, "_clk"}, clk_freq_b, DEFAULT_CLK);
        checkOutput({tag, "_bclk_en"}, 32'(bclk_en_b), 32'd0);
        checkOutput({tag, "_done"}, 32'(cfg_done_b), 32'd0);
        checkOutput({tag, "_rej"}, 32'(cfg_rej_b), 32'd0);
        checkOutput({tag, "_err"}, 32'(cfg_err_b), 32'd0);
        checkOutput({tag, "_hold"}, 32'(uart_hold_b), 32'd1);
        checkOutput({tag, "_busy"}, 32'(cfg_busy_b), 32'd1);
    endtask

    logic [31:0] rate_tbl [7] = '{32'd9600, 32'd19200, 32'd38400, 32'd57600,
                                  32'd115200, 32'd12345, 32'd31250};

    initial begin
        int cyc;
        bit seen;
        rstn = 1'b0; cfg_req = 1'b0; cfg_baud = '0; cfg_clk = '0;
        tx_busy = 1'b0; rx_busy = 1'b0;
        rstn_b = 1'b0; cfg_req_b = 1'b0; cfg_baud_b = DEFAULT_BAUD;

        repeat (3) step();
        checkOutput("rst_baud", baud_rate, DEFAULT_BAUD);
        checkOutput("rst_clk", clk_freq, DEFAULT_CLK);
        checkOutput("rst_bclk_en", 32'(bclk_en), 32'd0);
        checkOutput("rst_done", 32'(cfg_done), 32'd0);
        checkOutput("rst_rej", 32'(cfg_rej), 32'd0);
        checkOutput("rst_err", 32'(cfg_err), 32'd0);
        checkOutput("rst_hold", 32'(uart_hold), 32'd1);
        checkOutput("rst_busy", 32'(cfg_busy), 32'd1);

        // Boot lock at 9600 on 50 MHz: first toggle about 325 cycles in.
        rstn = 1'b1;
        waitDone("boot", 1000, cyc);
        checkOutput("boot_latency_window", 32'(cyc >= 320 && cyc <= 345), 32'd1);
        checkOutput("boot_baud", baud_rate, DEFAULT_BAUD);
        checkOutput("boot_bclk_en", 32'(bclk_en), 32'd1);
        checkOutput("boot_err", 32'(cfg_err), 32'd0);
        checkOutput("boot_hold", 32'(uart_hold), 32'd0);
        step();

        runConfig("bad_12345", 32'd12345, DEFAULT_CLK, 0, 1'b0, 1'b0);
        runConfig("cfg_115200", BAUD_115200, DEFAULT_CLK, 0, 1'b0, 1'b0);
        runConfig("drain_tx20", BAUD_19200, DEFAULT_CLK, 20, 1'b1, 1'b0);
        runConfig("rej_check", BAUD_38400, DEFAULT_CLK, 0, 1'b0, 1'b1);

        for (int k = 0; k < 6; k++) begin
            logic [31:0] rb, rf;
            rb = rate_tbl[$urandom_range(0, 6)];
            rf = ($urandom_range(0, 1) == 1) ? 32'd50000000 : 32'd25000000;
            runConfig($sformatf("rand%0d", k), rb, rf, int'($urandom_range(0, 4)),
                      1'(($urandom_range(0, 1))), 1'b0);
        end

        // Second instance: bclk never toggles, so both the attempt and its
        // revert time out (APPLY + CHECK + LOCK + FAIL, twice).
        rstn_b = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 1000) begin
            step();
            cyc++;
            if (cfg_done_b) seen = 1'b1;
        end
        checkOutput("tmo_done_seen", 32'(seen), 32'd1);
        checkOutput("tmo_latency", 32'(cyc), 32'(2 * (2 + CHECK_N + TIMEOUT_B)));
        checkOutput("tmo_bclk_en", 32'(bclk_en_b), 32'd0);
        checkOutput("tmo_err", 32'(cfg_err_b), 32'd1);
        checkOutput("tmo_hold", 32'(uart_hold_b), 32'd0);
        checkOutput("tmo_busy", 32'(cfg_busy_b), 32'd0);
        checkOutput("tmo_baud", baud_rate_b, DEFAULT_BAUD);

        cfg_baud_b = BAUD_115200;
        cfg_req_b  = 1'b1;
        step();
        cfg_req_b  = 1'b0;
        repeat (30) step();
        checkOutput("midlock_baud", baud_rate_b, BAUD_115200);
        checkOutput("midlock_bclk_en", 32'(bclk_en_b), 32'd1);
        checkOutput("midlock_err", 32'(cfg_err_b), 32'd0);
        #2;
        rstn_b = 1'b0;
        #1;
        checkResetB("midlock_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_cfg_ctrl.md
BAUD_CFG_CTRL -- requirements
Module: baud_cfg_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_BAUD, 32'd9600, baud rate applied after reset.
REQ-002 SHALL have parameter DEFAULT_CLK, 32'd50000000, clock frequency in Hz applied after reset.
REQ-003 SHALL have parameter CHECK_CYCLES, 4, cycles spent sampling the generator error flag.
REQ-004 SHALL have parameter LOCK_TIMEOUT, 65536, maximum cycles to wait for the first bclk toggle.
REQ-005 SHALL have port clk, input, 1, single clock.
REQ-006 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port cfg_req, input, 1, one-cycle request to apply cfg_baud/cfg_clk.
REQ-008 SHALL have port cfg_baud, input, 32, requested baud rate.
REQ-009 SHALL have port cfg_clk, input, 32, requested clock frequency.
REQ-010 SHALL have ports tx_busy and rx_busy, input, 1 each, UART frame in progress.
REQ-011 SHALL have ports BR_config_error and bclk, input, 1 each, from the baud clock generator.
REQ-012 SHALL have ports BAUD_RATE and CLK_FREQ, output, 32 each, registered values driven to the generator.
REQ-013 SHALL have port bclk_en, output, 1, generator enable.
REQ-014 SHALL have port uart_hold, output, 1, blocks new TX/RX frame starts.
REQ-015 SHALL have ports cfg_busy (1, level), cfg_done (1, pulse), cfg_rej (1, pulse) and cfg_err (1, sticky), all outputs.

Function
REQ-016 SHALL implement the states IDLE, DRAIN, APPLY, CHECK, LOCK, DONE and FAIL.
REQ-017 SHALL accept cfg_req only in IDLE: latch cfg_baud/cfg_clk into the pending registers, clear cfg_err, then enter DRAIN.
REQ-018 SHALL treat cfg_req in any other state as ignored: cfg_rej pulses on the next cycle and the pending registers are unchanged.
REQ-019 SHALL in DRAIN hold uart_hold=1 and move to APPLY in the first cycle where tx_busy=0 and rx_busy=0; DRAIN has no timeout.
REQ-020 SHALL in APPLY, lasting exactly 1 cycle, load BAUD_RATE/CLK_FREQ from the pending registers with bclk_en=0.
REQ-021 SHALL in CHECK drive bclk_en=1 for CHECK_CYCLES cycles; BR_config_error=1 in any of those cycles -> FAIL; otherwise -> LOCK.
REQ-022 SHALL in LOCK detect a bclk toggle (bclk != bclk registered one cycle earlier) and then go to DONE.
REQ-023 SHALL in LOCK go to FAIL if BR_config_error=1 or if LOCK_TIMEOUT cycles elapse without a toggle.
REQ-024 SHALL in DONE, lasting exactly 1 cycle, copy pending into the last-good registers, pulse cfg_done, and return to IDLE.
REQ-025 SHALL in FAIL set cfg_err=1; if the failed attempt was not a revert, load pending from last-good, mark the attempt as a revert, and go to APPLY with no DRAIN.
REQ-026 SHALL in FAIL, when a revert also fails, drive bclk_en=0, release uart_hold, pulse cfg_done, and go to IDLE.
REQ-027 SHALL assert uart_hold and cfg_busy in every state except IDLE.
REQ-028 SHALL keep bclk_en=1 in IDLE after any successful lock.
REQ-029 SHALL use a single 32-bit timer for CHECK and LOCK that reloads on each state entry and saturates at zero.
REQ-030 SHALL treat simultaneous BR_config_error=1 and a bclk toggle in LOCK as FAIL.

Reset
REQ-031 SHALL on rstn=0 asynchronously set BAUD_RATE=DEFAULT_BAUD, CLK_FREQ=DEFAULT_CLK, bclk_en=0, cfg_done=cfg_rej=cfg_err=0, and timer=0.
REQ-032 SHALL on rstn=0 load pending and last-good with the defaults, clear the revert flag, and set state=APPLY.
REQ-033 SHALL keep uart_hold=cfg_busy=1 from reset until the first DONE or the terminal FAIL.
REQ-034 SHALL, when reset is asserted mid-operation (any state), abandon the sequence and restart from the defaults.

Structure
REQ-035 SHALL place the state encoding, DEFAULT_BAUD, DEFAULT_CLK and the supported-baud constants in the shared UART package.
REQ-036 SHALL place the reloadable CHECK/LOCK timer in one sub-module, cfg_timer, instantiated once.

Verification
REQ-037 SHALL cover: reset, generator at 50 MHz/16 -> APPLY, CHECK, first toggle about 325 cycles later, cfg_done, bclk_en=1, BAUD_RATE=9600.
REQ-038 SHALL cover: cfg_req with 115200/50000000 -> BAUD_RATE=115200, cfg_done, and cfg_err=0.
REQ-039 SHALL cover: cfg_req with 12345 -> BR_config_error in CHECK, FAIL, revert to 9600, cfg_done, cfg_err=1, and bclk_en=1.
REQ-040 SHALL cover: tx_busy held high for 20 cycles after cfg_req -> DRAIN for 20 cycles with uart_hold=1 and BAUD_RATE unchanged until APPLY.
REQ-041 SHALL cover: a second cfg_req during CHECK -> cfg_rej pulse, with the first configuration completing unaffected.
REQ-042 SHALL cover: LOCK_TIMEOUT=100 with bclk stuck low -> FAIL at cycle 100, failed revert, bclk_en=0, cfg_err=1; then rstn pulsed mid-LOCK -> all outputs at reset values.
